seq_divider4: RTL
=================

SEQ_DIVIDER4 -- requirements
Module: seq_divider4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1: request a division; accepted only while busy=0.
REQ-005 The block SHALL have port dividend, input, WIDTH: unsigned dividend, sampled on the accepted start.
REQ-006 The block SHALL have port divisor, input, WIDTH: unsigned divisor, sampled on the accepted start.
REQ-007 The block SHALL have port busy, output, 1: high in RUN and DONE states.
REQ-008 The block SHALL have port done, output, 1: one-cycle pulse when results are valid.
REQ-009 The block SHALL have port quotient, output, WIDTH: unsigned quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH: unsigned remainder.
REQ-011 The block SHALL have port dbz, output, 1: divide-by-zero flag for the latest result.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start with divisor!=0; IDLE->DONE on start with divisor==0; RUN->DONE after WIDTH RUN cycles; DONE->IDLE unconditionally.
REQ-013 Operands SHALL be latched into internal registers on the accepted start; later input changes SHALL have no effect on the running operation.
REQ-014 Algorithm SHALL be restoring shift-subtract: per RUN cycle, partial remainder (WIDTH+1 bits) shifts left taking the next dividend MSB; trial = partial - divisor; no borrow -> partial=trial, quotient bit=1; borrow -> partial kept, quotient bit=0.
REQ-015 An iteration counter SHALL count 0..WIDTH-1 in RUN and SHALL clear on every accepted start.
REQ-016 Latency SHALL be fixed: start accepted in cycle N -> done=1 in cycle N+WIDTH+1 (N+5 for WIDTH=4), independent of operand values.
REQ-017 Divide by zero SHALL complete in cycle N+1 with quotient=all ones, remainder=dividend, dbz=1.
REQ-018 dbz SHALL be 0 for every non-zero divisor result and SHALL update together with quotient/remainder.
REQ-019 quotient, remainder, dbz SHALL update only when entering DONE and SHALL hold until the next result.
REQ-020 start while busy=1 (RUN or DONE) SHALL be ignored with no effect on state or outputs.
REQ-021 done SHALL be high exactly in DONE; back-to-back operation SHALL allow the next start in the cycle after DONE (IDLE).
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for all divisor != 0.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0, dbz=0, internal operand registers=0.
REQ-024 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow, and the first rising edge after rst_n deasserts SHALL treat the block as IDLE.

Structure
REQ-025 FSM state encoding (IDLE/RUN/DONE) and default WIDTH SHALL live in a shared package, divider_pkg.
REQ-026 The trial subtraction SHALL be a sub-module sub_stage (WIDTH+1-bit two's-complement add of inverted divisor with carry-in 1, borrow = inverted carry-out), reusing the team's ripple add/subtract style.
REQ-027 Implementation SHALL contain one subtractor instance only, reused across RUN cycles, no combinational divider array.

Verification
REQ-028 Start 13/4 in cycle 0 -> done in cycle 5, quotient=3, remainder=1, dbz=0.
REQ-029 Start 15/1 -> quotient=15, remainder=0; start 3/7 -> quotient=0, remainder=3; both at cycle N+5.
REQ-030 Start 9/0 -> done in cycle 1, quotient=15, remainder=9, dbz=1; then 8/2 -> quotient=4, remainder=0, dbz=0.
REQ-031 Start 14/3 in cycle 0, start 1/1 with changed operands in cycles 2 and 5 -> done only in cycle 5, quotient=4, remainder=2; start in cycle 6 accepted.
REQ-032 Start 12/5, assert rst_n low in cycle 3 for one cycle -> outputs all 0, no done pulse; subsequent 12/5 -> quotient=2, remainder=2.
REQ-033 Exhaustive sweep of all 256 operand pairs back-to-back -> every result matches REQ-022 or REQ-017, latency per REQ-016.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package divider_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/sub_stage.sv
// Ripple-carry trial subtractor: a - b as a + ~b + 1, borrow is the inverted carry-out.
module sub_stage #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    always_comb begin
        logic c;
        logic bi;
        diff = '0;
        c    = 1'b1;
        for (int i = 0; i < W; i++) begin
            bi      = ~b[i];
            diff[i] = a[i] ^ bi ^ c;
            c       = (a[i] & bi) | (a[i] & c) | (bi & c);
        end
        borrow = ~c;
    end

endmodule

// File: rtl/seq_divider4.sv
// Sequential unsigned divider: one restoring shift-subtract step per RUN cycle,
// a single shared trial subtractor, fixed latency of WIDTH+1 cycles.
module seq_divider4
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   part_q, part_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH:0]   part_next;
    logic [WIDTH-1:0] dvd_next;

    // dvd_q doubles as the quotient accumulator: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    assign shifted   = {part_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign part_next = borrow ? shifted : trial;
    assign dvd_next  = {dvd_q[WIDTH-2:0], ~borrow};

    sub_stage #(.W(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    cnt_d  = '0;
                    part_d = '0;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                part_d = part_next;
                dvd_d  = dvd_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    quo_d   = dvd_next;
                    rem_d   = part_next[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule
